sdr_init_refresh_seq: RTL and testbench
=======================================

// Module: sdr_init_refresh_seq
// PURPOSE
//  Owns the SDRAM command bus during power-up init and periodic refresh.
//  Sequence: NOP wait, PRECHARGE-ALL, 2x AUTO-REFRESH, LOAD-MODE.
//  Then generates refresh ticks and requests the bus from the transfer path via a req/gnt handshake.
//  Its outputs are muxed onto sdr_* pins by the core whenever cmd_own=1.
// PARAMETERS
//  INIT_WAIT     500  NOP cycles after reset release (power-up stable time)
//  T_RP          3    cycles from PRECHARGE to next command
//  T_RFC         7    cycles from AUTO-REFRESH to next command
//  T_MRD         2    cycles from LOAD-MODE to init_done
//  REF_INTERVAL  780  cycles between refresh ticks
//  REF_MAX_PEND  4    saturation limit of pending-refresh counter
//  SDR_AW        13   SDRAM address width
// PORTS
//  sdram_clk     in   1       controller clock
//  sdram_resetn  in   1       async active-low reset
//  cfg_sdr_mode  in   SDR_AW  mode-register value, sampled at LOAD-MODE issue
//  ref_gnt       in   1       transfer path idle and all banks closable; grants bus
//  sdr_cs_n      out  1       chip select
//  sdr_ras_n     out  1       command strobe
//  sdr_cas_n     out  1       command strobe
//  sdr_we_n      out  1       command strobe
//  sdr_addr      out  SDR_AW  address (A10=1 on PRECHARGE-ALL)
//  sdr_ba        out  2       bank address, always 0
//  cmd_own       out  1       sequencer drives command bus
//  init_done     out  1       init sequence complete (stays 1 until reset)
//  ref_req       out  1       refresh pending, requesting bus
//  ref_urgent    out  1       pending count == REF_MAX_PEND
//  ref_overflow  out  1       sticky: tick arrived while saturated
// BEHAVIOUR
//  Reset (async, sdram_resetn=0):
//   - cs_n=1, ras/cas/we=1, addr=0, ba=0, cmd_own=1, init_done=0
//   - ref_req=0, ref_urgent=0, ref_overflow=0, pend=0, FSM=RST_WAIT
//   - Reset mid-operation aborts any sequence; init restarts from RST_WAIT.
//  Commands (ras,cas,we), each driven for exactly 1 cycle with cs_n=0:
//   - NOP=111, PRE=010, AREF=001, LMR=000
//   - All other cycles are NOP with cs_n=0 (cs_n=1 only in reset).
//  FSM states and transitions:
//   - RST_WAIT: INIT_WAIT NOPs -> IPRE
//   - IPRE: PRE, A10=1, wait T_RP -> IREF1
//   - IREF1: AREF, wait T_RFC -> IREF2
//   - IREF2: AREF, wait T_RFC -> ILMR
//   - ILMR: LMR, addr=cfg_sdr_mode, wait T_MRD -> IDLE
//   - IDLE: entering sets init_done=1 and cmd_own=0
//   - IDLE -> RPRE when ref_req & ref_gnt sampled high
//   - RPRE: cmd_own=1, PRE-ALL, wait T_RP -> RAREF
//   - RAREF: AREF, wait T_RFC; pend-=1; cmd_own=0 -> IDLE
//   - Next command issues exactly T_x cycles after the previous one.
//  Refresh timing:
//   - Interval counter runs only when init_done=1.
//   - Tick every REF_INTERVAL cycles: pend+=1, saturating at REF_MAX_PEND.
//   - Tick while saturated: pend unchanged, ref_overflow<=1 (sticky).
//   - Tick and RAREF completion in the same cycle: pend unchanged.
//  Handshake:
//   - ref_req = (pend!=0) & state==IDLE (registered).
//   - ref_req holds until granted; ref_gnt is ignored while ref_req=0.
//   - ref_req drops in the cycle RPRE is entered.
//   - If pend is still >0 after RAREF, ref_req reasserts 1 cycle after IDLE re-entry.
//  Latency: ref_gnt sampled -> PRE on bus at next sdram_clk edge.
//  Widths: timers are $clog2(max param)+1 bits; pend is $clog2(REF_MAX_PEND+1) bits.
// STRUCTURE
//  sdr_seq_pkg:
//   - sdr_cmd_e {NOP,PRE,AREF,LMR} with ras/cas/we encodings
//   - seq_state_e
//   - CMD_* constants
//  Sub-module sdr_ref_timer: interval counter, pend counter, urgent/overflow flags.
//   - Inputs: init_done, ref_done pulse. Output: pend.
//  Top holds the FSM, wait timer and command/address registers.
// TESTING (INIT_WAIT=500,T_RP=3,T_RFC=7,T_MRD=2,REF_INTERVAL=100,MAX_PEND=4)
//  1. Reset release at cycle 0, cfg_sdr_mode=13'h033:
//     -> NOP cycles 0-499; PRE(A10=1)@500; AREF@503; AREF@510
//     -> LMR addr=033@517; init_done=1 and cmd_own=0 @519
//  2. ref_gnt tied 1 -> ref_req 100 cycles after init_done; PRE next cycle;
//     AREF 3 cycles later; cmd_own drops 7 cycles after AREF; pend back to 0.
//  3. ref_gnt=0 for 450 cycles -> pend=4, ref_urgent=1, ref_overflow=1 after tick 5;
//     then ref_gnt=1 -> 4 back-to-back PRE/AREF pairs; ref_req=0 at end; overflow stays 1.
//  4. Assert sdram_resetn=0 two cycles after a refresh PRE:
//     -> all outputs at reset values in the same cycle, no clock edge needed;
//     -> after release, full init repeats (PRE@500).
//  5. Force tick coincident with RAREF completion (pend=1) -> pend stays 1; ref_req reasserts.
//  6. ref_gnt pulsed while ref_req=0 -> no command issued, cmd_own stays 0.

Source files
------------

// File: rtl/sdr_init_refresh_seq_pkg.sv
// Shared command encodings, sequencer states and helpers for the SDRAM init/refresh sequencer.
package sdr_seq_pkg;

    // Values are the {ras_n, cas_n, we_n} pin encodings.
    typedef enum logic [2:0] {
        CMD_LMR  = 3'b000,
        CMD_AREF = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_NOP  = 3'b111
    } sdr_cmd_e;

    typedef enum logic [2:0] {
        RST_WAIT,
        IPRE,
        IREF1,
        IREF2,
        ILMR,
        IDLE,
        RPRE,
        RAREF
    } seq_state_e;

    localparam int unsigned A10_BIT = 10;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdr_init_refresh_seq_if.sv
// Command bus and refresh handshake between the sequencer (master) and the controller core (slave).
interface sdr_init_refresh_seq_if #(
    parameter int SDR_AW = 13
);
    logic [SDR_AW-1:0] cfg_sdr_mode;
    logic              ref_gnt;
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [SDR_AW-1:0] sdr_addr;
    logic [1:0]        sdr_ba;
    logic              cmd_own;
    logic              init_done;
    logic              ref_req;
    logic              ref_urgent;
    logic              ref_overflow;

    modport master (
        input  cfg_sdr_mode, ref_gnt,
        output sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
        output cmd_own, init_done, ref_req, ref_urgent, ref_overflow
    );

    modport slave (
        output cfg_sdr_mode, ref_gnt,
        input  sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
        input  cmd_own, init_done, ref_req, ref_urgent, ref_overflow
    );
endinterface

// File: rtl/sdr_init_refresh_seq_ref_timer.sv
// Refresh interval counter and saturating pending-refresh counter with urgent/overflow flags.
module sdr_ref_timer #(
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned REF_MAX_PEND = 4,
    localparam int unsigned PW = $clog2(REF_MAX_PEND + 1)
) (
    input  logic          sdram_clk,
    input  logic          sdram_resetn,
    input  logic          i_init_done,
    input  logic          i_ref_done,
    output logic          o_tick,
    output logic [PW-1:0] o_pend,
    output logic          o_urgent,
    output logic          o_overflow
);
    localparam int unsigned    IW       = $clog2(REF_INTERVAL) + 1;
    localparam logic [IW-1:0]  IVL_LAST = IW'(REF_INTERVAL - 1);
    localparam logic [PW-1:0]  PEND_MAX = PW'(REF_MAX_PEND);

    logic [IW-1:0] r_ivl;
    logic [PW-1:0] r_pend;
    logic          r_overflow;
    logic          w_tick;
    logic          w_sat;

    assign w_tick = i_init_done && (r_ivl == IVL_LAST);
    assign w_sat  = (r_pend == PEND_MAX);

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_ivl      <= '0;
            r_pend     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_init_done) r_ivl <= w_tick ? '0 : r_ivl + 1'b1;
            // A tick landing on a refresh completion cancels out.
            if (w_tick && !i_ref_done) begin
                if (w_sat) r_overflow <= 1'b1;
                else       r_pend     <= r_pend + 1'b1;
            end else if (!w_tick && i_ref_done && (r_pend != '0)) begin
                r_pend <= r_pend - 1'b1;
            end
        end
    end

    assign o_tick     = w_tick;
    assign o_pend     = r_pend;
    assign o_urgent   = w_sat;
    assign o_overflow = r_overflow;
endmodule

// File: rtl/sdr_init_refresh_seq.sv
// SDRAM power-up init sequencer and refresh issuer; owns the command bus while cmd_own=1.
module sdr_init_refresh_seq
    import sdr_seq_pkg::*;
#(
    parameter int unsigned INIT_WAIT    = 500,
    parameter int unsigned T_RP         = 3,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned REF_MAX_PEND = 4,
    parameter int unsigned SDR_AW       = 13
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    sdr_init_refresh_seq_if.master bus
);
    localparam int unsigned       TW      = $clog2(max4(INIT_WAIT, T_RP, T_RFC, T_MRD)) + 1;
    localparam int unsigned       PW      = $clog2(REF_MAX_PEND + 1);
    localparam logic [TW-1:0]     LD_INIT = TW'(INIT_WAIT);
    localparam logic [TW-1:0]     LD_RP   = TW'(T_RP - 1);
    localparam logic [TW-1:0]     LD_RFC  = TW'(T_RFC - 1);
    localparam logic [TW-1:0]     LD_MRD  = TW'(T_MRD - 1);
    localparam logic [SDR_AW-1:0] ADDR_PRE_ALL = SDR_AW'(1) << A10_BIT;

    seq_state_e        r_state;
    logic [TW-1:0]     r_timer;
    sdr_cmd_e          r_cmd;
    logic [SDR_AW-1:0] r_addr;
    logic              r_cs_n;
    logic              r_cmd_own;
    logic              r_init_done;
    logic              r_ref_req;

    logic              w_timer_zero;
    logic              w_ref_done;
    logic              w_tick;
    logic [PW-1:0]     w_pend;
    logic              w_urgent;
    logic              w_overflow;

    // Timer is loaded with T-1 on issue so the next command lands exactly T cycles later.
    assign w_timer_zero = (r_timer == '0);
    assign w_ref_done   = (r_state == RAREF) && w_timer_zero;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_state     <= RST_WAIT;
            r_timer     <= LD_INIT;
            r_cmd       <= CMD_NOP;
            r_addr      <= '0;
            r_cs_n      <= 1'b1;
            r_cmd_own   <= 1'b1;
            r_init_done <= 1'b0;
            r_ref_req   <= 1'b0;
        end else begin
            r_cs_n <= 1'b0;
            r_cmd  <= CMD_NOP;
            r_addr <= '0;
            if (!w_timer_zero) r_timer <= r_timer - 1'b1;
            case (r_state)
                RST_WAIT: if (w_timer_zero) begin
                    r_cmd   <= CMD_PRE;
                    r_addr  <= ADDR_PRE_ALL;
                    r_timer <= LD_RP;
                    r_state <= IPRE;
                end
                IPRE: if (w_timer_zero) begin
                    r_cmd   <= CMD_AREF;
                    r_timer <= LD_RFC;
                    r_state <= IREF1;
                end
                IREF1: if (w_timer_zero) begin
                    r_cmd   <= CMD_AREF;
                    r_timer <= LD_RFC;
                    r_state <= IREF2;
                end
                IREF2: if (w_timer_zero) begin
                    r_cmd   <= CMD_LMR;
                    r_addr  <= bus.cfg_sdr_mode;
                    r_timer <= LD_MRD;
                    r_state <= ILMR;
                end
                ILMR: if (w_timer_zero) begin
                    r_init_done <= 1'b1;
                    r_cmd_own   <= 1'b0;
                    r_state     <= IDLE;
                end
                IDLE: begin
                    // Include this cycle's tick so ref_req rises together with pend.
                    if (r_ref_req && bus.ref_gnt) begin
                        r_cmd     <= CMD_PRE;
                        r_addr    <= ADDR_PRE_ALL;
                        r_timer   <= LD_RP;
                        r_cmd_own <= 1'b1;
                        r_ref_req <= 1'b0;
                        r_state   <= RPRE;
                    end else begin
                        r_ref_req <= (w_pend != '0) || w_tick;
                    end
                end
                RPRE: if (w_timer_zero) begin
                    r_cmd   <= CMD_AREF;
                    r_timer <= LD_RFC;
                    r_state <= RAREF;
                end
                RAREF: if (w_timer_zero) begin
                    r_cmd_own <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= RST_WAIT;
            endcase
        end
    end

    sdr_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .REF_MAX_PEND (REF_MAX_PEND)
    ) u_ref_timer (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .i_init_done  (r_init_done),
        .i_ref_done   (w_ref_done),
        .o_tick       (w_tick),
        .o_pend       (w_pend),
        .o_urgent     (w_urgent),
        .o_overflow   (w_overflow)
    );

    assign bus.sdr_cs_n                                  = r_cs_n;
    assign {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} = r_cmd;
    assign bus.sdr_addr                                  = r_addr;
    assign bus.sdr_ba                                    = '0;
    assign bus.cmd_own                                   = r_cmd_own;
    assign bus.init_done                                 = r_init_done;
    assign bus.ref_req                                   = r_ref_req;
    assign bus.ref_urgent                                = w_urgent;
    assign bus.ref_overflow                              = w_overflow;
endmodule

// File: tb/tb_sdr_init_refresh_seq.sv
// Scoreboard bench: directed stimulus queues expected commands; a negedge monitor pops and checks them.
module tb_sdr_init_refresh_seq;
    localparam logic [2:0] C_LMR  = 3'b000;
    localparam logic [2:0] C_AREF = 3'b001;
    localparam logic [2:0] C_PRE  = 3'b010;
    localparam logic [2:0] C_NOP  = 3'b111;
    localparam logic [12:0] A10   = 13'h0400;

    typedef struct {
        int          cyc;
        logic [2:0]  cmd;
        logic [12:0] addr;
        logic [12:0] mask;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    ev_t  exp_q[$];

    sdr_init_refresh_seq_if #(.SDR_AW(13)) bus ();

    sdr_init_refresh_seq #(
        .INIT_WAIT    (500),
        .T_RP         (3),
        .T_RFC        (7),
        .T_MRD        (2),
        .REF_INTERVAL (100),
        .REF_MAX_PEND (4),
        .SDR_AW       (13)
    ) dut (
        .sdram_clk    (clk),
        .sdram_resetn (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = index of the last rising edge since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= -1;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] cmd, input logic [12:0] addr,
                        input logic [12:0] mask);
        ev_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.addr = addr;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cs_n",      bus.sdr_cs_n, 1'b1);
        chk("rst_cmd",       {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n}, C_NOP);
        chk("rst_addr",      bus.sdr_addr, 13'h0);
        chk("rst_ba",        bus.sdr_ba, 2'b00);
        chk("rst_cmd_own",   bus.cmd_own, 1'b1);
        chk("rst_init_done", bus.init_done, 1'b0);
        chk("rst_ref_req",   bus.ref_req, 1'b0);
        chk("rst_urgent",    bus.ref_urgent, 1'b0);
        chk("rst_overflow",  bus.ref_overflow, 1'b0);
    endtask

    task automatic push_init(input logic [12:0] mode);
        push(500, C_PRE,  A10,  A10);
        push(503, C_AREF, 13'h0, 13'h0);
        push(510, C_AREF, 13'h0, 13'h0);
        push(517, C_LMR,  mode, 13'h1fff);
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] c;
        ev_t        e;
        if (rst_n) begin
            c = {bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n};
            chk("cs_n_active", bus.sdr_cs_n, 1'b0);
            if (c != C_NOP) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", {32'(cyc), 29'd0, c}, '1);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_event{cyc,own,ba,cmd,addr}",
                        {12'd0, 32'(cyc), 1'b0, bus.cmd_own, bus.sdr_ba, c, bus.sdr_addr & e.mask},
                        {12'd0, 32'(e.cyc), 2'b01, 2'b00, e.cmd, e.addr & e.mask});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=cyc %0d required=finished", cyc);
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ref_gnt      = 1'b0;
        bus.cfg_sdr_mode = 13'h033;
        repeat (3) @(negedge clk);
        #1 chk_reset_vals();
        #1 rst_n = 1'b1;

        // Power-up init
        push_init(13'h033);
        wait_cyc(518);
        chk("init_done_pre",  bus.init_done, 1'b0);
        chk("cmd_own_pre",    bus.cmd_own, 1'b1);
        wait_cyc(519);
        chk("init_done_set",  bus.init_done, 1'b1);
        chk("cmd_own_release", bus.cmd_own, 1'b0);

        // Grant while nothing is requested does nothing
        wait_cyc(540); bus.ref_gnt = 1'b1;
        wait_cyc(543); bus.ref_gnt = 1'b0;
        wait_cyc(545);
        chk("stray_gnt_own", bus.cmd_own, 1'b0);
        chk("stray_gnt_req", bus.ref_req, 1'b0);

        // Grant tied high: refresh right after each tick
        wait_cyc(560);
        bus.ref_gnt = 1'b1;
        push(620, C_PRE, A10, A10);
        push(623, C_AREF, 13'h0, 13'h0);
        push(720, C_PRE, A10, A10);
        push(723, C_AREF, 13'h0, 13'h0);
        wait_cyc(618); chk("req_before_tick", bus.ref_req, 1'b0);
        wait_cyc(619); chk("req_at_tick",     bus.ref_req, 1'b1);
        wait_cyc(620); chk("req_drop_rpre",   bus.ref_req, 1'b0);
        wait_cyc(629); chk("own_during_aref", bus.cmd_own, 1'b1);
        wait_cyc(630); chk("own_after_aref",  bus.cmd_own, 1'b0);
        wait_cyc(740); bus.ref_gnt = 1'b0;

        // Starve grants: saturate and overflow, then drain 4 back-to-back
        wait_cyc(1118); chk("urgent_3",     bus.ref_urgent, 1'b0);
        wait_cyc(1119); chk("urgent_4",     bus.ref_urgent, 1'b1);
                        chk("req_held",     bus.ref_req, 1'b1);
        wait_cyc(1218); chk("overflow_pre", bus.ref_overflow, 1'b0);
        wait_cyc(1219); chk("overflow_set", bus.ref_overflow, 1'b1);
        wait_cyc(1229);
        for (int i = 0; i < 4; i++) begin
            push(1230 + 12 * i, C_PRE, A10, A10);
            push(1233 + 12 * i, C_AREF, 13'h0, 13'h0);
        end
        push(1320, C_PRE, A10, A10);
        push(1323, C_AREF, 13'h0, 13'h0);
        bus.ref_gnt = 1'b1;
        wait_cyc(1239); chk("urgent_until_done", bus.ref_urgent, 1'b1);
        wait_cyc(1240); chk("urgent_cleared",    bus.ref_urgent, 1'b0);
        wait_cyc(1290);
        chk("req_drained",     bus.ref_req, 1'b0);
        chk("overflow_sticky", bus.ref_overflow, 1'b1);
        wait_cyc(1340); bus.ref_gnt = 1'b0;

        // Tick coincident with refresh completion keeps pend at 1
        push(1509, C_PRE, A10, A10);
        push(1512, C_AREF, 13'h0, 13'h0);
        push(1521, C_PRE, A10, A10);
        push(1524, C_AREF, 13'h0, 13'h0);
        wait_cyc(1419); chk("req_tick_1419", bus.ref_req, 1'b1);
        wait_cyc(1508); bus.ref_gnt = 1'b1;
        wait_cyc(1519); chk("req_at_reentry",  bus.ref_req, 1'b0);
        wait_cyc(1520); chk("req_reasserted",  bus.ref_req, 1'b1);
        wait_cyc(1535); bus.ref_gnt = 1'b0;
        wait_cyc(1540); chk("req_after_pend1", bus.ref_req, 1'b0);

        // Reset two cycles after a refresh PRE
        push(1630, C_PRE, A10, A10);
        wait_cyc(1629); bus.ref_gnt = 1'b1;
        wait_cyc(1632);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        bus.ref_gnt      = 1'b0;
        bus.cfg_sdr_mode = 13'h1a5;
        chk("queue_before_reinit", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        push_init(13'h1a5);
        wait_cyc(499); chk("reinit_own",  bus.cmd_own, 1'b1);
        wait_cyc(518); chk("reinit_done_pre", bus.init_done, 1'b0);
        wait_cyc(519); chk("reinit_done_set", bus.init_done, 1'b1);
        wait_cyc(530); chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
